// File: rtl/segfile_pkg.sv
// Shared constants and types for the segment register file.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package segfile_pkg;

  localparam int NUM_SEG      = 8;
  localparam int SEG_IDX_W    = 3;
  localparam int BASE_W       = 16;
  localparam int LIM_W        = 20;
  localparam int TAG_W        = 7;
  localparam int NUM_PORTS    = 4;
  localparam int NUM_LIM_INIT = 6;
  localparam int PTC_W        = 64;

  typedef logic [BASE_W-1:0]    base_t;
  typedef logic [LIM_W-1:0]     lim_t;
  typedef logic [TAG_W-1:0]     tag_t;
  typedef logic [SEG_IDX_W-1:0] seg_idx_t;

endpackage

// File: rtl/segfile_segreg.sv
// Single segment entry: base, limit and tag with load and reset.
// Latency: load visible one clock after the edge that performs it.
// Backpressure: none; a load is always accepted, reset wins over load.
module segreg
  import segfile_pkg::*;
(
  input  logic  clk,
  input  logic  clr,
  input  lim_t  lim_init,
  input  logic  ld,
  input  base_t base_d,
  input  tag_t  tag_d,
  output base_t base_q,
  output lim_t  lim_q,
  output tag_t  tag_q
);

  // Reset clears base/tag and reloads the limit; limit is otherwise frozen.
  always_ff @(posedge clk) begin
    if (clr) begin
      base_q <= '0;
      tag_q  <= '0;
      lim_q  <= lim_init;
    end else if (ld) begin
      base_q <= base_d;
      tag_q  <= tag_d;
    end
  end

endmodule

// File: rtl/segfile.sv
// Eight-entry segment register file, four write ports and four read ports.
// Latency: reads are combinational; writes visible after the performing edge.
// Backpressure: none; all enabled writes are taken, highest port wins a clash.
module segfile
  import segfile_pkg::*;
(
  input  logic                           clk,
  input  logic                           clr,
  input  logic [NUM_PORTS*BASE_W-1:0]    base_in,
  input  logic [NUM_LIM_INIT*LIM_W-1:0]  lim_inits,
  input  logic [NUM_PORTS*SEG_IDX_W-1:0] ld_addr,
  input  logic [NUM_PORTS*SEG_IDX_W-1:0] rd_addr,
  input  logic [NUM_PORTS-1:0]           ld_en,
  input  logic [NUM_PORTS-1:0]           dest,
  input  tag_t                           data_ptcid,
  input  tag_t                           new_ptcid,
  output logic [NUM_PORTS*BASE_W-1:0]    base_out,
  output logic [NUM_PORTS*LIM_W-1:0]     lim_out,
  output logic [NUM_PORTS*PTC_W-1:0]     ptc_out
);

  base_t seg_base [NUM_SEG];
  lim_t  seg_lim  [NUM_SEG];
  tag_t  seg_tag  [NUM_SEG];

  for (genvar e = 0; e < NUM_SEG; e++) begin : g_seg
    logic  ld;
    base_t base_d;
    tag_t  tag_d;
    lim_t  lim_init;

    // Entries beyond the initialiser list reset to a zero limit.
    if (e < NUM_LIM_INIT) begin : g_lim_init
      assign lim_init = lim_inits[LIM_W*e +: LIM_W];
    end else begin : g_lim_zero
      assign lim_init = '0;
    end

    // Scan ports low to high so the highest enabled port targeting this entry wins.
    always_comb begin
      ld     = 1'b0;
      base_d = '0;
      tag_d  = '0;
      for (int p = 0; p < NUM_PORTS; p++) begin
        if (ld_en[p] && (ld_addr[SEG_IDX_W*p +: SEG_IDX_W] == SEG_IDX_W'(e))) begin
          ld     = 1'b1;
          base_d = base_in[BASE_W*p +: BASE_W];
          tag_d  = dest[p] ? new_ptcid : data_ptcid;
        end
      end
    end

    segreg u_segreg (
      .clk      (clk),
      .clr      (clr),
      .lim_init (lim_init),
      .ld       (ld),
      .base_d   (base_d),
      .tag_d    (tag_d),
      .base_q   (seg_base[e]),
      .lim_q    (seg_lim[e]),
      .tag_q    (seg_tag[e])
    );
  end

  // Independent combinational read muxes; stored state only, no write bypass.
  always_comb begin
    base_out = '0;
    lim_out  = '0;
    ptc_out  = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      base_out[BASE_W*p +: BASE_W] = seg_base[rd_addr[SEG_IDX_W*p +: SEG_IDX_W]];
      lim_out[LIM_W*p +: LIM_W]    = seg_lim[rd_addr[SEG_IDX_W*p +: SEG_IDX_W]];
      ptc_out[PTC_W*p +: PTC_W]    = PTC_W'(seg_tag[rd_addr[SEG_IDX_W*p +: SEG_IDX_W]]);
    end
  end

endmodule

// File: tb/tb_segfile.sv
// Scoreboard bench for segfile: stimulus queues expected read values,
// a negedge monitor pops and compares the ones due in the current cycle.
// Expected values are hand-computed constants.
module tb_segfile;

  logic         clk = 1'b0;
  logic         clr;
  logic [63:0]  base_in;
  logic [119:0] lim_inits;
  logic [11:0]  ld_addr;
  logic [11:0]  rd_addr;
  logic [3:0]   ld_en;
  logic [3:0]   dest;
  logic [6:0]   data_ptcid;
  logic [6:0]   new_ptcid;
  logic [63:0]  base_out;
  logic [79:0]  lim_out;
  logic [255:0] ptc_out;

  segfile dut (
    .clk        (clk),
    .clr        (clr),
    .base_in    (base_in),
    .lim_inits  (lim_inits),
    .ld_addr    (ld_addr),
    .rd_addr    (rd_addr),
    .ld_en      (ld_en),
    .dest       (dest),
    .data_ptcid (data_ptcid),
    .new_ptcid  (new_ptcid),
    .base_out   (base_out),
    .lim_out    (lim_out),
    .ptc_out    (ptc_out)
  );

  always #5 clk = ~clk;

  localparam logic [119:0] LIM_INIT_VEC =
    {20'h007ff, 20'h003ff, 20'h003ff, 20'h04000, 20'h011ff, 20'h04fff};

  localparam int K_BASE = 0;
  localparam int K_LIM  = 1;
  localparam int K_PTC  = 2;

  typedef struct {
    int          cyc;
    int          kind;
    int          port;
    logic [63:0] exp;
  } item_t;

  item_t sbq[$];
  int    cyc    = 0;
  int    total  = 0;
  int    passed = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic string kind_name(input int kind);
    case (kind)
      K_BASE:  return "base_out";
      K_LIM:   return "lim_out";
      default: return "ptc_out";
    endcase
  endfunction

  function automatic logic [63:0] actual(input int kind, input int port);
    case (kind)
      K_BASE:  return 64'(base_out[16*port +: 16]);
      K_LIM:   return 64'(lim_out[20*port +: 20]);
      default: return ptc_out[64*port +: 64];
    endcase
  endfunction

  task automatic exp_rd(input int kind, input int port, input logic [63:0] v);
    item_t it;
    it.cyc  = cyc;
    it.kind = kind;
    it.port = port;
    it.exp  = v;
    sbq.push_back(it);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: compare every expectation due this cycle at the falling edge.
  always @(negedge clk) begin
    item_t       it;
    logic [63:0] a;
    while (sbq.size() > 0 && sbq[0].cyc <= cyc) begin
      it = sbq.pop_front();
      a  = actual(it.kind, it.port);
      total++;
      if (it.cyc != cyc)
        $display("FAIL stale %s[%0d] cyc %0d: not checked, due cyc %0d", kind_name(it.kind), it.port, cyc, it.cyc);
      else if (a !== it.exp)
        $display("FAIL %s[%0d] cyc %0d: got %h, expected %h", kind_name(it.kind), it.port, cyc, a, it.exp);
      else
        passed++;
    end
  end

  initial begin
    clr = 1'b0; base_in = '0; lim_inits = LIM_INIT_VEC; ld_addr = '0; rd_addr = '0;
    ld_en = '0; dest = '0; data_ptcid = '0; new_ptcid = '0;

    // Reset cycle.
    step();
    clr = 1'b1;

    // Reset read-back, entries 0..3.
    step();
    clr = 1'b0;
    rd_addr = {3'd3, 3'd2, 3'd1, 3'd0};
    exp_rd(K_LIM, 0, 64'h04fff); exp_rd(K_LIM, 1, 64'h011ff);
    exp_rd(K_LIM, 2, 64'h04000); exp_rd(K_LIM, 3, 64'h003ff);
    for (int p = 0; p < 4; p++) begin
      exp_rd(K_BASE, p, 64'h0);
      exp_rd(K_PTC, p, 64'h0);
    end

    // Entries 4..7; also disturb lim_inits with clr low.
    step();
    rd_addr = {3'd7, 3'd6, 3'd5, 3'd4};
    lim_inits = '1;
    exp_rd(K_LIM, 0, 64'h003ff); exp_rd(K_LIM, 1, 64'h007ff);
    exp_rd(K_LIM, 2, 64'h0);     exp_rd(K_LIM, 3, 64'h0);

    // Load entries 0..3; reads still show pre-load state.
    step();
    ld_en = 4'b1111; ld_addr = {3'd3, 3'd2, 3'd1, 3'd0};
    base_in = {16'h3030, 16'h2020, 16'h1010, 16'h0000};
    rd_addr = {3'd3, 3'd2, 3'd1, 3'd0};
    exp_rd(K_LIM, 0, 64'h04fff); exp_rd(K_LIM, 1, 64'h011ff);
    exp_rd(K_BASE, 1, 64'h0);    exp_rd(K_BASE, 3, 64'h0);

    // Load entries 4..7; read back 0..3.
    step();
    ld_addr = {3'd7, 3'd6, 3'd5, 3'd4};
    base_in = {16'h7070, 16'h6060, 16'h5050, 16'h4040};
    exp_rd(K_BASE, 0, 64'h0000); exp_rd(K_BASE, 1, 64'h1010);
    exp_rd(K_BASE, 2, 64'h2020); exp_rd(K_BASE, 3, 64'h3030);

    // Read back 4..7.
    step();
    ld_en = '0;
    rd_addr = {3'd7, 3'd6, 3'd5, 3'd4};
    exp_rd(K_BASE, 0, 64'h4040); exp_rd(K_BASE, 1, 64'h5050);
    exp_rd(K_BASE, 2, 64'h6060); exp_rd(K_BASE, 3, 64'h7070);

    // Collision on entry 2: port 0 (data tag) vs port 3 (rename tag).
    step();
    ld_en = 4'b1001; ld_addr = {3'd2, 3'd0, 3'd0, 3'd2};
    base_in = {16'h3333, 16'h0000, 16'h0000, 16'h1111};
    dest = 4'b1000; data_ptcid = 7'h11; new_ptcid = 7'h22;
    rd_addr = {3'd2, 3'd2, 3'd2, 3'd2};
    exp_rd(K_BASE, 0, 64'h2020);

    // All four ports read entry 2 after the clash.
    step();
    ld_en = '0; dest = '0;
    for (int p = 0; p < 4; p++) exp_rd(K_BASE, p, 64'h3333);
    exp_rd(K_PTC, 0, 64'h22); exp_rd(K_PTC, 3, 64'h22);

    // Rename load to entry 1.
    step();
    ld_en = 4'b0001; ld_addr = {3'd0, 3'd0, 3'd0, 3'd1};
    dest = 4'b0001; new_ptcid = 7'h5A; base_in = 64'hABCD;
    rd_addr = {3'd0, 3'd0, 3'd0, 3'd1};

    // Data load to entry 1 while reading it: old value visible.
    step();
    dest = 4'b0000; data_ptcid = 7'h03; base_in = 64'h1234;
    exp_rd(K_PTC, 0, 64'h5A); exp_rd(K_BASE, 0, 64'hABCD);

    // New value now visible; dest toggled with ld_en low.
    step();
    ld_en = '0; dest = 4'b1111; new_ptcid = 7'h7F;
    exp_rd(K_PTC, 0, 64'h03); exp_rd(K_BASE, 0, 64'h1234);

    step();
    dest = '0;
    exp_rd(K_PTC, 0, 64'h03); exp_rd(K_BASE, 0, 64'h1234);

    // Reset together with loads on every port.
    step();
    lim_inits = LIM_INIT_VEC; clr = 1'b1;
    ld_en = 4'b1111; ld_addr = {3'd7, 3'd6, 3'd5, 3'd1};
    base_in = '1; dest = 4'b1111;

    step();
    clr = 1'b0; ld_en = '0; dest = '0;
    rd_addr = {3'd7, 3'd6, 3'd5, 3'd1};
    exp_rd(K_LIM, 0, 64'h011ff); exp_rd(K_LIM, 1, 64'h007ff);
    exp_rd(K_LIM, 2, 64'h0);     exp_rd(K_LIM, 3, 64'h0);
    for (int p = 0; p < 4; p++) begin
      exp_rd(K_BASE, p, 64'h0);
      exp_rd(K_PTC, p, 64'h0);
    end

    step();
    rd_addr = {3'd3, 3'd2, 3'd4, 3'd0};
    exp_rd(K_LIM, 0, 64'h04fff); exp_rd(K_LIM, 1, 64'h003ff);
    exp_rd(K_LIM, 2, 64'h04000); exp_rd(K_LIM, 3, 64'h003ff);
    for (int p = 0; p < 4; p++) exp_rd(K_BASE, p, 64'h0);

    repeat (3) step();
    if (sbq.size() != 0) begin
      total++;
      $display("FAIL drain: %0d expectations left unchecked, expected 0", sbq.size());
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/segfile.md
SEGFILE -- requirements
Module: segfile

Interface
REQ-001 SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-002 SHALL have port clr, input, 1 bit: reset, synchronous and active-high.
REQ-003 SHALL have port base_in, input, 64 bits: four 16-bit write-port bases; port i is bits [16i+15:16i].
REQ-004 SHALL have port lim_inits, input, 120 bits: six 20-bit limit initialisers; entry j is bits [20j+19:20j], for segment registers 0..5.
REQ-005 SHALL have port ld_addr, input, 12 bits: four 3-bit write-port register indices; port i is bits [3i+2:3i].
REQ-006 SHALL have port rd_addr, input, 12 bits: four 3-bit read-port register indices; port i is bits [3i+2:3i].
REQ-007 SHALL have port ld_en, input, 4 bits: per-write-port load enable.
REQ-008 SHALL have port dest, input, 4 bits: per-write-port rename flag.
REQ-009 SHALL have port data_ptcid, input, 7 bits: tag written with a plain data load.
REQ-010 SHALL have port new_ptcid, input, 7 bits: tag written with a rename.
REQ-011 SHALL have port base_out, output, 64 bits: four 16-bit read-port bases, packed as base_in.
REQ-012 SHALL have port lim_out, output, 80 bits: four 20-bit read-port limits.
REQ-013 SHALL have port ptc_out, output, 256 bits: four 64-bit read-port tag words.

Function
REQ-014 SHALL hold 8 segment entries (index 0..7); each entry has base[15:0], lim[19:0] and tag[6:0].
REQ-015 SHALL load the limits only on reset: lim of entry j = lim_inits entry j for j=0..5; lim of entries 6 and 7 = 20'h00000.
REQ-016 SHALL leave limits unchanged when clr is low, regardless of lim_inits changes.
REQ-017 SHALL, when ld_en[i]=1 at a clock edge, write base_in[i] into base of entry ld_addr[i].
REQ-018 SHALL set tag of entry ld_addr[i] to data_ptcid when ld_en[i]=1 and dest[i]=0.
REQ-019 SHALL set tag of entry ld_addr[i] to new_ptcid when ld_en[i]=1 and dest[i]=1.
REQ-020 SHALL ignore dest[i] when ld_en[i]=0; the entry is unchanged.
REQ-021 SHALL resolve multiple enabled ports targeting the same entry in one cycle by giving the highest port index priority for both base and tag.
REQ-022 SHALL drive reads combinationally: base_out[i] = base[rd_addr[i]], lim_out[i] = lim[rd_addr[i]], ptc_out[i] = {57'b0, tag[rd_addr[i]]}.
REQ-023 SHALL NOT bypass writes to reads; a write becomes visible on the read ports after the clock edge that performs it.
REQ-024 SHALL make all four read ports independent; any port may read any entry, including the same entry as another port.

Reset
REQ-025 SHALL, on a clock edge with clr=1, clear all bases and tags to 0 and load limits per REQ-015.
REQ-026 SHALL give reset priority over all loads in the same cycle.
REQ-027 SHALL, after reset, drive base_out=0, ptc_out=0 and lim_out equal to the reset limit of each addressed entry.

Structure
REQ-028 SHALL place the entry count (8), the base/limit/tag widths (16/20/7) and the port count (4) as constants in the shared RAVE package.
REQ-029 SHALL use one sub-module, segreg, for a single entry holding base, lim and tag with its own load and reset logic.
REQ-030 SHALL keep write-port priority muxing and read muxing in segfile.

Verification
REQ-031 SHALL test reset read-back: lim_inits = 04fff, 011ff, 04000, 003ff, 003ff, 007ff, then a reset cycle and rd_addr 0..3 -> lim_out 04fff, 011ff, 04000, 003ff and base_out 0.
REQ-032 SHALL test loading all entries: cycle 1 loads entries 0..3 with bases 0000, 1010, 2020, 3030; cycle 2 loads entries 4..7 with bases 4040, 5050, 6060, 7070; rd_addr 0..3 then 4..7 -> the same values.
REQ-033 SHALL test collision: ports 0 and 3 both load entry 2 with 1111 and 3333 -> base 3333.
REQ-034 SHALL test tags: ld_en=0001, dest=0001, new_ptcid=7'h5A to entry 1 -> ptc_out = 64'h5A; then dest=0000, data_ptcid=7'h03 -> ptc_out = 64'h03.
REQ-035 SHALL test no-bypass: reading an entry in the same cycle it is loaded returns the old value, and the new value on the next cycle.
REQ-036 SHALL test reset mid-operation: clr=1 with ld_en=1111 -> all bases 0 and limits restored.
